// File: rtl/es_ports.sv
// es_ports: port-side I/O controller, four output ports and four input ports.
// Output ports: one holding register per port, drained by a valid/ready handshake,
// with a sticky overrun flag.
// Input ports: four-phase valid/ack handshake, one holding register per port,
// read by the core through data_in/id_in.
// Build option: define ES_SYNC_EN to pass each in_valid through a SYNC_STAGES-deep
// flop chain. Use it when the producer is asynchronous to clk. Without it,
// in_valid drives the input FSM directly.
module es_ports #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we_out,
  input  logic               s_out_src,
  input  logic [1:0]         id_out,
  input  logic [WIDTH-1:0]   data_reg,
  input  logic [WIDTH-1:0]   data_mem,
  input  logic               re_in,
  input  logic [1:0]         id_in,
  output logic [WIDTH-1:0]   data_in,
  output logic [3:0]         in_pending,
  output logic [4*WIDTH-1:0] out_data,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [3:0]         out_ovr,
  input  logic [4*WIDTH-1:0] in_bus,
  input  logic [3:0]         in_valid,
  output logic [3:0]         in_ack
);

  typedef enum logic {ST_IDLE, ST_ACK} in_state_t;

  // The synchroniser depth is only meaningful as 2 or 3 flops.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("es_ports: SYNC_STAGES must be 2 or 3");
  end

  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_in_data [4];

  assign w_wdata = s_out_src ? data_mem : data_reg;
  assign data_in = w_in_data[id_in];

  for (genvar gi = 0; gi < 4; gi++) begin : g_port
    // ---------------- output side ----------------
    logic             w_wr;
    logic             w_xfer;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_out_ovr;

    assign w_wr   = we_out && (id_out == 2'(gi));
    assign w_xfer = r_out_valid && out_ready[gi];

    // Load on write. Otherwise drain on transfer. A write to a full port that is
    // not transferring in the same edge marks an overrun.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_out_data  <= '0;
        r_out_valid <= 1'b0;
        r_out_ovr   <= 1'b0;
      end else begin
        if (w_wr) begin
          r_out_data  <= w_wdata;
          r_out_valid <= 1'b1;
          if (r_out_valid && !w_xfer) r_out_ovr <= 1'b1;
        end else if (w_xfer) begin
          r_out_valid <= 1'b0;
        end
      end
    end

    assign out_data[gi*WIDTH +: WIDTH] = r_out_data;
    assign out_valid[gi]               = r_out_valid;
    assign out_ovr[gi]                 = r_out_ovr;

    // ---------------- input side ----------------
    logic             w_vs;
    logic             w_rd;
    logic             w_capture;
    in_state_t        r_state;
    in_state_t        w_state_next;
    logic             r_pending;
    logic [WIDTH-1:0] r_in_data;

`ifdef ES_SYNC_EN
    logic [SYNC_STAGES-1:0] r_sync;

    // Bring the asynchronous request into the clk domain.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) r_sync <= '0;
      else       r_sync <= {r_sync[SYNC_STAGES-2:0], in_valid[gi]};
    end

    assign w_vs = r_sync[SYNC_STAGES-1];
`else
    assign w_vs = in_valid[gi];
`endif

    assign w_rd = re_in && (id_in == 2'(gi));

    // Handshake state register. The state itself is the registered ack.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_next;
    end

    // Next state. A capture is held off while the previous word is still unread.
    always_comb begin
      w_state_next = r_state;
      w_capture    = 1'b0;
      case (r_state)
        ST_IDLE: if (w_vs && !r_pending) begin
          w_capture    = 1'b1;
          w_state_next = ST_ACK;
        end
        ST_ACK:  if (!w_vs) w_state_next = ST_IDLE;
        default: w_state_next = ST_IDLE;
      endcase
    end

    // Capture sets pending and a core read clears it. Capture needs pending=0,
    // so the two never collide on a word that is still unread.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_pending <= 1'b0;
        r_in_data <= '0;
      end else if (w_capture) begin
        r_pending <= 1'b1;
        r_in_data <= in_bus[gi*WIDTH +: WIDTH];
      end else if (w_rd) begin
        r_pending <= 1'b0;
      end
    end

    assign in_ack[gi]     = (r_state == ST_ACK);
    assign in_pending[gi] = r_pending;
    assign w_in_data[gi]  = r_in_data;
  end

endmodule

// File: tb/tb_es_ports.sv
// Directed self-checking bench for es_ports. The expected values are worked out
// by hand. The ack latency follows the build: 3 edges with ES_SYNC_EN (2 stages),
// 1 edge without.
module tb_es_ports;

`ifdef ES_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        we_out = 1'b0;
  logic        s_out_src = 1'b0;
  logic [1:0]  id_out = '0;
  logic [7:0]  data_reg = '0;
  logic [7:0]  data_mem = '0;
  logic        re_in = 1'b0;
  logic [1:0]  id_in = '0;
  logic [7:0]  data_in;
  logic [3:0]  in_pending;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready = '0;
  logic [3:0]  out_ovr;
  logic [31:0] in_bus = '0;
  logic [3:0]  in_valid = '0;
  logic [3:0]  in_ack;

  int n_checks = 0;
  int n_errors = 0;

  es_ports #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .we_out(we_out), .s_out_src(s_out_src),
    .id_out(id_out), .data_reg(data_reg), .data_mem(data_mem),
    .re_in(re_in), .id_in(id_in), .data_in(data_in), .in_pending(in_pending),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ovr(out_ovr), .in_bus(in_bus), .in_valid(in_valid), .in_ack(in_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Advance one rising edge. Sampling and driving both happen 1 time unit after it.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Reset from power-up
    #2 reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_ovr",   32'(out_ovr),   32'h0);
    check("rst_pending",   32'(in_pending), 32'h0);
    check("rst_in_ack",    32'(in_ack),    32'h0);
    check("rst_out_data",  out_data,       32'h0);
    check("rst_data_in",   32'(data_in),   32'h0);

    // Output write of data_reg to port 1, then drain it
    we_out = 1'b1; id_out = 2'd1; s_out_src = 1'b0; data_reg = 8'hA5;
    tick(1);
    we_out = 1'b0;
    check("wr1_valid", 32'(out_valid), 32'h2);
    check("wr1_data",  32'(out_data[15:8]), 32'hA5);
    tick(1);
    check("wr1_hold",  32'(out_valid[1]), 32'h1);
    out_ready = 4'b0010;
    tick(1);
    out_ready = 4'b0000;
    check("wr1_drain", 32'(out_valid[1]), 32'h0);

    // Overrun on port 3: two writes from data_mem with no ready
    we_out = 1'b1; id_out = 2'd3; s_out_src = 1'b1; data_mem = 8'h11;
    tick(1);
    data_mem = 8'h22;
    tick(1);
    we_out = 1'b0;
    check("ovr3_data",  32'(out_data[31:24]), 32'h22);
    check("ovr3_flag",  32'(out_ovr), 32'h8);
    check("ovr3_valid", 32'(out_valid[3]), 32'h1);

    // Port 2: the second write coincides with a transfer, so there is no overrun
    we_out = 1'b1; id_out = 2'd2; data_mem = 8'h11;
    tick(1);
    data_mem = 8'h22; out_ready = 4'b0100;
    tick(1);
    we_out = 1'b0;
    check("wx2_ovr",   32'(out_ovr[2]), 32'h0);
    check("wx2_valid", 32'(out_valid[2]), 32'h1);
    check("wx2_data",  32'(out_data[23:16]), 32'h22);
    tick(1);
    out_ready = 4'b0000;
    check("wx2_drain", 32'(out_valid[2]), 32'h0);

    // Input handshake on port 0
    in_bus[7:0] = 8'h3C; in_valid[0] = 1'b1; id_in = 2'd0;
    tick(LAT - 1);
    check("in0_ack_early", 32'(in_ack[0]), 32'h0);
    tick(1);
    check("in0_ack",  32'(in_ack[0]), 32'h1);
    check("in0_pend", 32'(in_pending[0]), 32'h1);
    check("in0_data", 32'(data_in), 32'h3C);
    in_valid[0] = 1'b0;
    tick(LAT - 1);
    check("in0_ack_hold", 32'(in_ack[0]), 32'h1);
    tick(1);
    check("in0_ack_drop", 32'(in_ack[0]), 32'h0);

    // Backpressure: port 0 is still pending, so a second request is held off
    in_bus[7:0] = 8'h7E; in_valid[0] = 1'b1;
    tick(LAT + 2);
    check("bp_no_ack", 32'(in_ack[0]), 32'h0);
    check("bp_data",   32'(data_in), 32'h3C);
    re_in = 1'b1;
    tick(1);
    re_in = 1'b0;
    check("bp_pend_clr", 32'(in_pending[0]), 32'h0);
    check("bp_ack_wait", 32'(in_ack[0]), 32'h0);
    tick(1);
    check("bp_ack",  32'(in_ack[0]), 32'h1);
    check("bp_pend", 32'(in_pending[0]), 32'h1);
    check("bp_data_new", 32'(data_in), 32'h7E);
    in_valid[0] = 1'b0;
    tick(LAT + 1);

    // Port 3: a read and an output write in the same edge both take effect
    in_bus[31:24] = 8'h5A; in_valid[3] = 1'b1;
    tick(LAT);
    check("in3_ack",  32'(in_ack[3]), 32'h1);
    check("in3_pend", 32'(in_pending[3]), 32'h1);
    re_in = 1'b1; id_in = 2'd3;
    we_out = 1'b1; id_out = 2'd3; s_out_src = 1'b0; data_reg = 8'hC3;
    tick(1);
    re_in = 1'b0; we_out = 1'b0;
    check("cc3_pend", 32'(in_pending[3]), 32'h0);
    check("cc3_out",  32'(out_data[31:24]), 32'hC3);
    check("cc3_din",  32'(data_in), 32'h5A);
    in_valid[3] = 1'b0;
    tick(LAT + 1);

    // Assert reset in the middle of an ACK on port 2
    in_bus[23:16] = 8'h99; in_valid[2] = 1'b1; id_in = 2'd2;
    tick(LAT);
    check("rs2_ack_pre", 32'(in_ack[2]), 32'h1);
    reset = 1'b1;
    #1;
    check("rs2_ack",   32'(in_ack), 32'h0);
    check("rs2_valid", 32'(out_valid), 32'h0);
    check("rs2_ovr",   32'(out_ovr), 32'h0);
    check("rs2_pend",  32'(in_pending), 32'h0);
    check("rs2_din",   32'(data_in), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    tick(LAT);
    check("rs2_recap_ack",  32'(in_ack[2]), 32'h1);
    check("rs2_recap_data", 32'(data_in), 32'h99);
    in_valid[2] = 1'b0;
    tick(LAT + 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
